// File: rtl/led_matrix_scan_controller.sv
// Purpose: five-column LED matrix scanner with a frame-locked irrigation mode latch
// Latency: outputs are registered and change on the same edge as the scan state
// Backpressure: none; enable=0 drops to IDLE on the sampling edge
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   enable            scan run request
//   mode              requested mode (01 sprinkler, 10 dripper, else invalid)
//   dec_data          mode latched at each frame boundary, fed to the decoder
//   dec_col_2/1/0     decoder row patterns (col 0/4, col 1/3, col 2)
//   col_n             active-low column enables
//   rows              active-high row drive
//   frame_start       one-cycle pulse at each frame boundary
//   busy              scanner is not idle
module led_matrix_scan_controller #(
    parameter int DRIVE_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] mode,
    output logic [1:0] dec_data,
    input  logic [6:0] dec_col_2,
    input  logic [6:0] dec_col_1,
    input  logic [6:0] dec_col_0,
    output logic [4:0] col_n,
    output logic [6:0] rows,
    output logic       frame_start,
    output logic       busy
);

    localparam int MAX_CYCLES = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    col_idx, col_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          boundary;
    logic          mode_ok;
    logic [4:0]    col_n_nx;
    logic [6:0]    rows_nx;

    assign mode_ok = (mode == 2'b01) || (mode == 2'b10);
    assign busy    = (state != IDLE);

    // Next-state: enable=0 outranks every other transition, so a frame
    // boundary coinciding with enable falling never fires.
    always_comb begin
        state_nx = state;
        col_nx   = col_idx;
        cnt_nx   = cnt;
        boundary = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = BLANK;
                    col_nx   = 3'd0;
                    cnt_nx   = '0;
                    boundary = 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_nx = IDLE;
                    col_nx   = 3'd0;
                    cnt_nx   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_nx = DRIVE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DRIVE: begin
                if (!enable) begin
                    state_nx = IDLE;
                    col_nx   = 3'd0;
                    cnt_nx   = '0;
                end else if (cnt == DRIVE_LAST) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    if (col_idx == 3'd4) begin
                        col_nx   = 3'd0;
                        boundary = 1'b1;
                    end else begin
                        col_nx = col_idx + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                col_nx   = 3'd0;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output image for the next state. Rows come only with a DRIVE column,
    // so the outputs can never show lit rows with every column off.
    // dec_data==00 marks an invalid-mode frame: rows stay dark all frame.
    // Entering DRIVE never coincides with a dec_data load, so the current
    // register value is the one for this frame.
    always_comb begin
        col_n_nx = 5'b11111;
        rows_nx  = 7'b0000000;
        if (state_nx == DRIVE) begin
            col_n_nx = ~(5'b00001 << col_nx);
            if (dec_data != 2'b00) begin
                case (col_nx)
                    3'd0, 3'd4: rows_nx = dec_col_2;
                    3'd1, 3'd3: rows_nx = dec_col_1;
                    3'd2:       rows_nx = dec_col_0;
                    default:    rows_nx = 7'b0000000;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            col_idx     <= 3'd0;
            cnt         <= '0;
            dec_data    <= 2'b00;
            col_n       <= 5'b11111;
            rows        <= 7'b0000000;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            col_idx     <= col_nx;
            cnt         <= cnt_nx;
            col_n       <= col_n_nx;
            rows        <= rows_nx;
            frame_start <= boundary;
            if (boundary) begin
                dec_data <= mode_ok ? mode : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_controller.sv
// Purpose: self-checking bench for led_matrix_scan_controller (DRIVE=3, BLANK=2)
// Latency: reference model tracks the position within the 25-clock frame
// Backpressure: not applicable
module tb_led_matrix_scan_controller;

    localparam int D     = 3;
    localparam int B     = 2;
    localparam int SLOT  = B + D;
    localparam int FRAME = 5 * SLOT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b01;
    logic [6:0] dec_col_2 = 7'h06;
    logic [6:0] dec_col_1 = 7'h23;
    logic [6:0] dec_col_0 = 7'h7F;
    logic [1:0] dec_data;
    logic [4:0] col_n;
    logic [6:0] rows;
    logic       frame_start;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    led_matrix_scan_controller #(.DRIVE_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .dec_data   (dec_data),
        .dec_col_2  (dec_col_2),
        .dec_col_1  (dec_col_1),
        .dec_col_0  (dec_col_0),
        .col_n      (col_n),
        .rows       (rows),
        .frame_start(frame_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: running flag plus position within the frame.
    bit         m_valid = 1'b0;
    bit         m_run   = 1'b0;
    int         m_p     = 0;
    logic [1:0] m_dd    = 2'b00;
    logic [4:0] e_col_n;
    logic [6:0] e_rows;
    logic       e_fs;
    logic       e_busy;

    always @(posedge clk) begin
        int c;
        int q;
        logic [6:0] pat;
        if (reset) begin
            m_valid = 1'b1;
            m_run   = 1'b0;
            m_p     = 0;
            m_dd    = 2'b00;
        end else if (!enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_p   = 0;
        end else begin
            m_p = (m_p + 1) % FRAME;
        end
        if (!reset && m_run && m_p == 0)
            m_dd = (mode == 2'b01 || mode == 2'b10) ? mode : 2'b00;
        e_col_n = 5'b11111;
        e_rows  = 7'h00;
        e_fs    = 1'b0;
        e_busy  = m_run;
        if (m_run) begin
            c    = m_p / SLOT;
            q    = m_p % SLOT;
            e_fs = (m_p == 0);
            if (q >= B) begin
                e_col_n = 5'b11111 & ~(5'b00001 << c);
                pat = (c == 2) ? dec_col_0 : ((c == 1 || c == 3) ? dec_col_1 : dec_col_2);
                if (m_dd != 2'b00) e_rows = pat;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [4:0] lit_cols [FRAME];
    logic [6:0] lit_rows [FRAME];

    initial begin
        lit_cols = '{5'h1F, 5'h1F, 5'h1E, 5'h1E, 5'h1E, 5'h1F, 5'h1F, 5'h1D, 5'h1D, 5'h1D,
                     5'h1F, 5'h1F, 5'h1B, 5'h1B, 5'h1B, 5'h1F, 5'h1F, 5'h17, 5'h17, 5'h17,
                     5'h1F, 5'h1F, 5'h0F, 5'h0F, 5'h0F};
        lit_rows = '{7'h00, 7'h00, 7'h06, 7'h06, 7'h06, 7'h00, 7'h00, 7'h23, 7'h23, 7'h23,
                     7'h00, 7'h00, 7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h00, 7'h23, 7'h23, 7'h23,
                     7'h00, 7'h00, 7'h06, 7'h06, 7'h06};
        fork
            begin : stimulus
                step(3);
                chk("reset_col_n", col_n, 5'h1F);
                chk("reset_rows", rows, 0);
                chk("reset_busy", busy, 0);
                chk("reset_fs", frame_start, 0);
                chk("reset_dec_data", dec_data, 0);
                reset = 1'b0;
                step(2);
                chk("idle_wait_busy", busy, 0);
                enable = 1'b1;
                // Frame 0: literal column/row sequence, mode switch in column 2
                for (int k = 0; k < FRAME; k++) begin
                    step(1);
                    chk("lit_col_n", col_n, lit_cols[k]);
                    chk("lit_rows", rows, lit_rows[k]);
                    chk("lit_fs", frame_start, (k == 0) ? 1 : 0);
                    chk("lit_dec_data", dec_data, 2'b01);
                    if (k == 13) mode = 2'b10;
                end
                step(1);                                  // frame cycle 25
                chk("period_fs", frame_start, 1);
                chk("mode_switch_dd", dec_data, 2'b10);
                step(5);
                mode = 2'b11;
                step(20);                                 // cycle 50
                chk("invalid_fs", frame_start, 1);
                chk("invalid_dd", dec_data, 2'b00);
                step(12);                                 // col 2 drive
                chk("invalid_col_n", col_n, 5'h1B);
                chk("invalid_rows", rows, 0);
                mode = 2'b01;
                step(13);                                 // cycle 75
                chk("restore_dd", dec_data, 2'b01);
                step(18);                                 // col 3 drive
                chk("col3_col_n", col_n, 5'h17);
                enable = 1'b0;
                step(1);
                chk("drop_col_n", col_n, 5'h1F);
                chk("drop_rows", rows, 0);
                chk("drop_busy", busy, 0);
                step(3);
                enable = 1'b1;
                step(1);
                chk("reen_fs", frame_start, 1);
                step(2);
                chk("reen_col_n", col_n, 5'h1E);
                step(6);                                  // col 1 drive
                chk("col1_col_n", col_n, 5'h1D);
                reset = 1'b1;
                step(1);
                chk("midreset_col_n", col_n, 5'h1F);
                chk("midreset_busy", busy, 0);
                chk("midreset_dd", dec_data, 0);
                chk("midreset_fs", frame_start, 0);
                reset = 1'b0;
                step(1);
                chk("restart_fs", frame_start, 1);
                chk("restart_dd", dec_data, 2'b01);
                // Randomised phase, checked by the model every cycle
                for (int i = 0; i < 3000; i++) begin
                    reset  = ($urandom_range(0, 199) == 0);
                    enable = ($urandom_range(0, 39) != 0);
                    if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
                    if ($urandom_range(0, 29) == 0) begin
                        dec_col_2 = 7'($urandom);
                        dec_col_1 = 7'($urandom);
                        dec_col_0 = 7'($urandom);
                    end
                    step(1);
                end
            end
            begin : compare
                forever begin
                    @(posedge clk);
                    #1;
                    if (m_valid) begin
                        chk("model_col_n", col_n, e_col_n);
                        chk("model_rows", rows, e_rows);
                        chk("model_fs", frame_start, e_fs);
                        chk("model_busy", busy, e_busy);
                        chk("model_dec_data", dec_data, m_dd);
                    end
                end
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan_controller.md
LED_MATRIX_SCAN_CONTROLLER -- requirements
Module: led_matrix_scan_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DRIVE_CYCLES, 1000, clocks a column is driven (legal >=1)
  BLANK_CYCLES, 4, clocks of blanking before each column (legal >=1)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  single system clock; all logic on rising edge
  reset  input  1  synchronous, active-high reset
  enable  input  1  scan run request
  mode  input  2  irrigation mode request: 01 sprinkler, 10 dripper, 00/11 invalid
  dec_data  output  2  mode presented to the irrigation mode decoder (registered)
  dec_col_2  input  7  decoder rows for physical columns 0 and 4
  dec_col_1  input  7  decoder rows for physical columns 1 and 3
  dec_col_0  input  7  decoder rows for physical column 2
  col_n  output  5  column enables, active-low, bit i = physical column i
  rows  output  7  row drive, active-high, bit i = row i
  frame_start  output  1  one-cycle pulse at the start of each frame
  busy  output  1  high whenever state is not IDLE

Function
REQ-003 The FSM SHALL have states IDLE, BLANK and DRIVE, plus a column index col_idx (0..4) and a cycle counter wide enough for max(DRIVE_CYCLES, BLANK_CYCLES)-1.
REQ-004 IDLE SHALL go to BLANK with col_idx=0 on the first clock where enable=1.
REQ-005 BLANK SHALL last exactly BLANK_CYCLES clocks and then go to DRIVE with the counter cleared.
REQ-006 DRIVE SHALL last exactly DRIVE_CYCLES clocks and then go to BLANK with col_idx+1, wrapping from 4 to 0.
REQ-007 Every entry into BLANK with col_idx=0 (from IDLE or on wrap) SHALL be a frame boundary: frame_start=1 for that one clock, and the same edge SHALL load dec_data from mode.
REQ-008 dec_data SHALL change only at frame boundaries and on reset, so no frame mixes two modes.
REQ-009 If mode is 00 or 11 at a frame boundary, dec_data SHALL load 00 and rows SHALL be forced to 0 for the whole frame (overriding decoder always-on columns); col_n still scans.
REQ-010 In IDLE and BLANK: col_n=5'b11111 and rows=7'b0000000.
REQ-011 In DRIVE: col_n SHALL have only bit col_idx low; rows SHALL be dec_col_2 for col_idx 0 or 4, dec_col_1 for col_idx 1 or 3, and dec_col_0 for col_idx 2, unless REQ-009 applies.
REQ-012 col_n and rows SHALL be registered outputs that change on the same edge as the state change. They SHALL never show two active columns, and they SHALL never show non-zero rows while all columns are off.
REQ-013 enable=0 sampled in BLANK or DRIVE SHALL move to IDLE on that edge, mid-column included. Outputs are blank from the next cycle. The next enable restarts at col_idx=0 with a new frame boundary.
REQ-014 If enable falls on the same edge as a frame boundary, IDLE SHALL win: no frame_start and no dec_data load.
REQ-015 A full frame SHALL be 5*(BLANK_CYCLES+DRIVE_CYCLES) clocks. frame_start SHALL repeat with exactly that period while enable stays 1.
REQ-016 Changes on mode between frame boundaries SHALL have no effect on any output.

Reset
REQ-017 reset=1 at a rising edge SHALL force, on that edge, state=IDLE, col_idx=0, counter=0, dec_data=00, col_n=5'b11111, rows=0, frame_start=0 and busy=0. reset has priority over enable.
REQ-018 reset asserted mid-operation SHALL abort the frame with the same result as REQ-017. After release, the block SHALL wait in IDLE until enable=1.

Verification (use DRIVE_CYCLES=3, BLANK_CYCLES=2; frame = 25 clocks)
REQ-019 Reset, enable=1, mode=01: frame_start pulses one clock after enable, then every 25 clocks. dec_data=01. col_n sequence is 11110, 11101, 11011, 10111, 01111, each held 3 clocks, with 11111 held 2 clocks between columns.
REQ-020 mode=10 and decoder stub with dec_col_2=7'h06, dec_col_1=7'h23, dec_col_0=7'h7F: rows=06, 23, 7F, 23, 06 during the DRIVE phases of columns 0-4, and rows=00 in every BLANK.
REQ-021 mode changes 01->10 during column 2 DRIVE: dec_data stays 01 until the next frame_start, then becomes 10 on that edge.
REQ-022 mode=11 at a frame boundary with dec_col_0=7'h7F: dec_data=00, rows=0 for the whole frame, and col_n still scans.
REQ-023 enable drops during column 3 DRIVE: next cycle col_n=11111, rows=0, busy=0. On re-enable, the first active column is 11110 and frame_start pulses.
REQ-024 reset pulsed for 1 clock during column 1 DRIVE with enable held at 1: outputs are at reset values the following cycle, then the block restarts with a fresh frame_start and dec_data reloaded from mode.
